// File: rtl/jb_rfsw_pkg.sv
// jb_rfsw_pkg: shared RF switch word encoding, decoding and FSM/fault types
package jb_rfsw_pkg;
  localparam logic PATH_TYPE_DPD  = 1'b0;
  localparam logic PATH_TYPE_VSWR = 1'b1;
  localparam logic RF_PORT1       = 1'b0;
  localparam logic RF_PORT2       = 1'b1;
  typedef struct packed {
    logic swa_en_n;
    logic swa;
    logic swb_en_n;
    logic swb;
    logic swc_en_n;
    logic swc;
  } rfsw_word_t;
  typedef struct packed {
    logic [1:0] ant_sel;
    logic       ant_none;
    logic       path_sel;
    logic       illegal;
  } rfsw_dec_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLING, ST_LOCKED, ST_FAULT} rfsw_state_t;
  typedef enum logic [1:0] {FC_NONE, FC_TIMEOUT, FC_ILLEGAL, FC_DRIFT} rfsw_fault_t;
  function automatic rfsw_word_t rfsw_encode(input logic [2:0] ant, input logic path);
    rfsw_word_t w;
    w.swa_en_n = 1'b0;
    w.swa      = (ant == 3'd0 || ant == 3'd3) ? RF_PORT1 : RF_PORT2;
    w.swb_en_n = !(ant == 3'd0 || ant == 3'd2);
    w.swb      = path == PATH_TYPE_DPD;
    w.swc_en_n = !(ant == 3'd1 || ant == 3'd3);
    w.swc      = path == PATH_TYPE_VSWR;
    return w;
  endfunction
  // b arm takes precedence when an illegal word enables both arms
  function automatic rfsw_dec_t rfsw_decode(input rfsw_word_t w);
    rfsw_dec_t d;
    d.illegal  = w.swa_en_n || (!w.swb_en_n && !w.swc_en_n) || (w.swb == w.swc);
    d.ant_none = w.swb_en_n && w.swc_en_n;
    d.ant_sel  = !w.swb_en_n ? (w.swa ? 2'd2 : 2'd0) : !w.swc_en_n ? (w.swa ? 2'd1 : 2'd3) : 2'd0;
    d.path_sel = w.swc;
    return d;
  endfunction
endpackage

// File: rtl/jb_rfsw_fb_debounce.sv
// jb_rfsw_fb_debounce: synchronises feedback lines and flags a word stable for STABLE_CNT cycles
module jb_rfsw_fb_debounce import jb_rfsw_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  rfsw_word_t fb,
  output rfsw_word_t word,
  output logic       accept,
  output logic       valid
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  rfsw_word_t [SYNC_STAGES-1:0] sync_q;
  rfsw_word_t prev;
  logic [CW-1:0] cnt;
  logic same;
  assign word   = sync_q[SYNC_STAGES-1];
  assign same   = word == prev;
  assign accept = same && cnt == CW'(STABLE_CNT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      prev   <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fb};
      prev   <= word;
      cnt    <= !same ? '0 : cnt == CW'(STABLE_CNT) ? cnt : cnt + 1'b1;
      valid  <= same && (valid || accept);
    end
endmodule

// File: rtl/jb_rfsw_demap.sv
// jb_rfsw_demap: decodes RF switch feedback and checks it against the commanded selection
module jb_rfsw_demap import jb_rfsw_pkg::*; #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CNT     = 16,
  parameter int SETTLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fb_swa_en_n,
  input  logic       fb_swa,
  input  logic       fb_swb_en_n,
  input  logic       fb_swb,
  input  logic       fb_swc_en_n,
  input  logic       fb_swc,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_ant_sel,
  input  logic       cmd_path_sel,
  input  logic       fault_clr,
  output logic       dec_valid,
  output logic [1:0] dec_ant_sel,
  output logic       dec_ant_none,
  output logic       dec_path_sel,
  output logic       dec_illegal,
  output logic       locked,
  output logic       busy,
  output logic [1:0] fault_code
);
  localparam int TW = $clog2(SETTLE_TIMEOUT + 1);
  rfsw_word_t sync_word, stable_q, cmd_q;
  rfsw_dec_t dec_q;
  rfsw_state_t state;
  rfsw_fault_t code;
  logic [TW-1:0] tmr;
  logic accept, match;
  jb_rfsw_fb_debounce #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CNT(STABLE_CNT)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .fb     (rfsw_word_t'({fb_swa_en_n, fb_swa, fb_swb_en_n, fb_swb, fb_swc_en_n, fb_swc})),
    .word   (sync_word),
    .accept (accept),
    .valid  (dec_valid)
  );
  assign match        = dec_valid && stable_q == cmd_q;
  assign dec_ant_sel  = dec_q.ant_sel;
  assign dec_ant_none = dec_q.ant_none;
  assign dec_path_sel = dec_q.path_sel;
  assign dec_illegal  = dec_q.illegal;
  assign locked       = state == ST_LOCKED;
  assign busy         = state == ST_SETTLING;
  assign fault_code   = code;
  // decoded fields hold their last stable value while the word is unsettled
  always_ff @(posedge clk)
    if (rst) begin
      stable_q <= '0;
      dec_q    <= '0;
    end else if (accept) begin
      stable_q <= sync_word;
      dec_q    <= rfsw_decode(sync_word);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      code  <= FC_NONE;
      tmr   <= '0;
      cmd_q <= '0;
    end else if (cmd_valid) begin
      state <= ST_SETTLING;
      code  <= FC_NONE;
      tmr   <= '0;
      cmd_q <= rfsw_encode(cmd_ant_sel, cmd_path_sel);
    end else
      case (state)
        ST_SETTLING: begin
          tmr <= tmr + 1'b1;
          if (match) state <= ST_LOCKED;
          else if (dec_valid && dec_q.illegal) begin
            state <= ST_FAULT;
            code  <= FC_ILLEGAL;
          end else if (tmr == TW'(SETTLE_TIMEOUT - 1)) begin
            state <= ST_FAULT;
            code  <= FC_TIMEOUT;
          end
        end
        ST_LOCKED: if (dec_valid && !match) begin
          state <= ST_FAULT;
          code  <= dec_q.illegal ? FC_ILLEGAL : FC_DRIFT;
        end
        ST_FAULT: if (fault_clr) begin
          state <= ST_IDLE;
          code  <= FC_NONE;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_jb_rfsw_demap.sv
// tb_jb_rfsw_demap: scoreboard bench for the RF switch readback decoder/checker
module tb_jb_rfsw_demap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_en_n, a, b_en_n, b, c_en_n, c;
  logic cmd_valid = 1'b0, fault_clr = 1'b0, cmd_path_sel = 1'b0;
  logic [2:0] cmd_ant_sel = 3'd0;
  logic dec_valid, dec_ant_none, dec_path_sel, dec_illegal, locked, busy;
  logic [1:0] dec_ant_sel, fault_code;
  int checks = 0, failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;
  logic [5:0] cur, w;
  logic pv = 1'b0;
  always #5 clk = ~clk;
  jb_rfsw_demap #(.SYNC_STAGES(2), .STABLE_CNT(16), .SETTLE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .fb_swa_en_n(a_en_n), .fb_swa(a), .fb_swb_en_n(b_en_n), .fb_swb(b),
    .fb_swc_en_n(c_en_n), .fb_swc(c),
    .cmd_valid(cmd_valid), .cmd_ant_sel(cmd_ant_sel), .cmd_path_sel(cmd_path_sel),
    .fault_clr(fault_clr),
    .dec_valid(dec_valid), .dec_ant_sel(dec_ant_sel), .dec_ant_none(dec_ant_none),
    .dec_path_sel(dec_path_sel), .dec_illegal(dec_illegal),
    .locked(locked), .busy(busy), .fault_code(fault_code)
  );
  // word layout {a_en_n, a, b_en_n, b, c_en_n, c}
  function automatic logic [5:0] enc(int ant, logic path);
    logic b_on, c_on, a_rf2;
    b_on  = ant == 0 || ant == 2;
    c_on  = ant == 1 || ant == 3;
    a_rf2 = !(ant == 0 || ant == 3);
    return {1'b0, a_rf2, !b_on, !path, !c_on, path};
  endfunction
  // expected {ant_sel, ant_none, path_sel, illegal}
  function automatic logic [4:0] ref_dec(logic [5:0] x);
    logic ill, none;
    int ant;
    ill  = x[5] || (!x[3] && !x[1]) || (x[2] == x[0]);
    none = x[3] && x[1];
    if (!x[3]) ant = x[4] ? 2 : 0;
    else if (!x[1]) ant = x[4] ? 1 : 3;
    else ant = 0;
    return {2'(ant), none, x[0], ill};
  endfunction
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic set_fb(logic [5:0] x, bit push);
    {a_en_n, a, b_en_n, b, c_en_n, c} = x;
    cur = x;
    if (push) exp_q.push_back(ref_dec(x));
  endtask
  task automatic cmd(int ant, logic path);
    cmd_valid = 1'b1;
    cmd_ant_sel = 3'(ant);
    cmd_path_sel = path;
    tick(1);
    cmd_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (dec_valid === 1'b1 && !pv) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dec_unexpected actual=%0h expected=none",
                 {dec_ant_sel, dec_ant_none, dec_path_sel, dec_illegal});
      end else begin
        e = exp_q.pop_front();
        if ({dec_ant_sel, dec_ant_none, dec_path_sel, dec_illegal} !== e) begin
          failures++;
          $display("FAIL dec_fields actual=%0h expected=%0h",
                   {dec_ant_sel, dec_ant_none, dec_path_sel, dec_illegal}, e);
        end
      end
    end
    pv = dec_valid === 1'b1;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    set_fb(enc(0, 0), 1);
    tick(3);
    chk("rst_dec", {dec_valid, dec_ant_sel, dec_ant_none, dec_path_sel, dec_illegal}, 0);
    chk("rst_fsm", {locked, busy, fault_code}, 0);
    rst = 1'b0;
    tick(25);
    for (int i = 0; i < 6; i++) begin
      w = 6'($urandom);
      if (w == cur) w = w ^ 6'd1;
      set_fb(w, 1);
      tick(22);
      chk("idle_no_fault", {locked, busy, fault_code}, 0);
    end
    set_fb(enc(0, 0), 1);
    tick(22);
    cmd(2, 1'b1);
    chk("lock_busy", busy, 1);
    tick(5);
    set_fb(enc(2, 1'b1), 1);
    tick(18);
    chk("lat_early", dec_valid, 0);
    tick(1);
    chk("lat_valid", dec_valid, 1);
    chk("lock_fields", {dec_ant_sel, dec_path_sel}, {2'd2, 1'b1});
    chk("lock_not_yet", locked, 0);
    tick(1);
    chk("lock_state", {locked, busy}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      int ant;
      logic p;
      ant = int'($urandom_range(0, 7));
      p = 1'($urandom_range(0, 1));
      cmd(ant, p);
      chk("rand_busy", busy, 1);
      if (enc(ant, p) != cur) set_fb(enc(ant, p), 1);
      tick(21);
      chk("rand_lock", {locked, fault_code}, 3'b100);
    end
    for (int i = 0; i < 10; i++) begin
      set_fb(cur ^ 6'b010000, 0);
      tick(1);
      chk("glitch_hold", {locked, fault_code}, 3'b100);
    end
    chk("glitch_valid_low", dec_valid, 0);
    exp_q.push_back(ref_dec(cur));
    tick(22);
    chk("glitch_relock", {locked, dec_valid, fault_code}, 4'b1100);
    cmd(0, 1'b0);
    if (enc(0, 0) != cur) set_fb(enc(0, 0), 1);
    tick(21);
    chk("drift_lock", locked, 1);
    set_fb(cur | 6'b010000, 1);
    tick(19);
    chk("drift_dec", {dec_valid, dec_ant_sel, fault_code}, {1'b1, 2'd2, 2'd0});
    tick(1);
    chk("drift_fault", {locked, fault_code}, {1'b0, 2'd3});
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("drift_clr", {locked, busy, fault_code}, 0);
    set_fb(enc(0, 0), 1);
    tick(22);
    cmd(1, 1'b0);
    tick(63);
    chk("tmo_pending", {busy, fault_code}, 3'b100);
    tick(1);
    chk("tmo_fault", {locked, busy, fault_code}, {2'b00, 2'd1});
    cmd(1, 1'b0);
    chk("ill_restart", {busy, fault_code}, 3'b100);
    set_fb(6'b000100, 1);
    tick(19);
    chk("ill_dec", {dec_valid, dec_illegal}, 2'b11);
    tick(1);
    chk("ill_fault", fault_code, 2);
    cmd_valid = 1'b1;
    fault_clr = 1'b1;
    cmd_ant_sel = 3'd1;
    cmd_path_sel = 1'b0;
    tick(1);
    cmd_valid = 1'b0;
    fault_clr = 1'b0;
    chk("prio", {busy, fault_code}, 3'b100);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_dec", {dec_valid, dec_ant_sel, dec_ant_none, dec_path_sel, dec_illegal}, 0);
    chk("rst_mid_fsm", {locked, busy, fault_code}, 0);
    rst = 1'b0;
    exp_q.push_back(ref_dec(cur));
    tick(25);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jb_rfsw_demap.md
# jb_rfsw_demap

Readback decoder and checker for the JB RF switch bank (HMC8038 SPDT switches a/b/c). It samples the six switch-control feedback lines returned from the radio board, synchronises and debounces them, and decodes them back into antenna/path selection. It then compares the result against the last commanded `ant_sel`/`path_sel`, raising a fault on settle timeout, illegal switch state, or post-lock drift. It sits in `srx_ctrl`, beside the forward switch map, and reports to the control register block.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on feedback lines (≥2).
- `STABLE_CNT`, 16: consecutive identical synchronised samples required before a word is accepted.
- `SETTLE_TIMEOUT`, 1024: cycles allowed from command to lock.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `fb_swa_en_n, fb_swa, fb_swb_en_n, fb_swb, fb_swc_en_n, fb_swc` in 1 each: asynchronous switch feedback.
- `cmd_valid` in 1: one-cycle pulse; a new command was applied to the forward map.
- `cmd_ant_sel` in 3: commanded antenna. Values 4–7 mean no antenna.
- `cmd_path_sel` in 1: commanded path. 0 = DPD, 1 = VSWR.
- `fault_clr` in 1: one-cycle pulse; leave FAULT.
- `dec_valid` out 1: decoded fields reflect a stable word.
- `dec_ant_sel` out 2: decoded antenna 0–3.
- `dec_ant_none` out 1: both b/c enables off.
- `dec_path_sel` out 1: decoded path.
- `dec_illegal` out 1: stable word is not producible by the forward map.
- `locked` out 1: state is LOCKED.
- `busy` out 1: state is SETTLING.
- `fault_code` out 2: 0 none, 1 timeout, 2 illegal, 3 drift. Holds its value while in FAULT.

## Operation
- Forward encoding (shared function `rfsw_encode`):
  - `swa_en_n` = 0.
  - `swb_en_n` = 0 iff ant ∈ {0, 2}.
  - `swc_en_n` = 0 iff ant ∈ {1, 3}.
  - `swa` = 0 iff ant ∈ {0, 3}.
  - `swb` = ~path.
  - `swc` = path.
- Decode, applied to the stable word:
  - Illegal if any of: `swa_en_n` = 1; both `swb_en_n` and `swc_en_n` = 0; `swb` == `swc`.
  - `dec_ant_none` = both enables 1.
  - b enabled: `dec_ant_sel` = `swa` ? 2 : 0.
  - c enabled: `dec_ant_sel` = `swa` ? 1 : 3.
  - `dec_path_sel` = `swc`.
- Debounce: counter clears when the synchronised word differs from the previous cycle's word, otherwise increments and saturates at `STABLE_CNT`. On reaching `STABLE_CNT`, the decoded fields register and `dec_valid` rises.
- Match: the stable raw 6-bit word equals `rfsw_encode(cmd_ant_sel, cmd_path_sel)`. The command is latched on `cmd_valid`.
- FSM:
  - IDLE: decoding only, no faults raised. `cmd_valid` → SETTLING.
  - SETTLING: timeout counter runs.
    - Stable match → LOCKED.
    - Stable illegal word → FAULT, code 2.
    - Stable legal non-match → keep waiting.
    - Timeout counter reaches `SETTLE_TIMEOUT` → FAULT, code 1.
  - LOCKED: stable non-match → FAULT, code 3 if legal, code 2 if illegal. Unstable samples (glitches) never fault.
  - FAULT: `fault_clr` → IDLE, with `fault_code` cleared.
- `cmd_valid` in any state relatches the command, clears `fault_code` and restarts SETTLING with the timeout counter at 0. It takes priority over `fault_clr` and over any same-cycle fault.

## Timing
- Reset values: all outputs 0; state IDLE; synchroniser, debounce and timeout counters 0.
- Latency: a feedback change held constant at the pins gives updated `dec_*` and `dec_valid` = 1 exactly `SYNC_STAGES + STABLE_CNT + 1` cycles later (19 at defaults).
- `dec_valid` falls the cycle after the synchronised word changes. The decoded fields hold their last values while `dec_valid` is low.
- FSM transitions take effect, and `locked`/`busy`/`fault_code` update, the cycle after `dec_valid` first rises on the qualifying word. Timeout fires on the cycle the count equals `SETTLE_TIMEOUT`, counting the `cmd_valid` cycle as 0.
- `rst` mid-SETTLING or mid-LOCKED returns to IDLE next cycle, with all outputs 0.

## Structure
- Package `jb_rfsw_pkg`:
  - `PATH_TYPE_DPD`/`PATH_TYPE_VSWR`, `RF_PORT1`/`RF_PORT2`.
  - `rfsw_word_t` packed struct of the six lines.
  - `rfsw_encode` and `rfsw_decode` functions.
  - FSM state enum and fault code enum.
- One sub-module, `jb_rfsw_fb_debounce`: synchroniser, stable counter and stable-word register, parameterised on `SYNC_STAGES` and `STABLE_CNT`.

## Test plan
- Lock: `cmd_valid` with ant = 2, path = 1; feedback driven 5 cycles later to en_n a/b/c = 0/0/1, swa/swb/swc = 1/0/1. Expect `dec_ant_sel` = 2, `dec_path_sel` = 1, `dec_valid` = 1 at +19 cycles, and `locked` = 1 one cycle later.
- Timeout: with `SETTLE_TIMEOUT` = 64, `cmd_valid` with ant = 1 while feedback stays at the ant = 0 encoding. Expect `fault_code` = 1 and `locked` = 0 at cycle 64 after the command.
- Illegal: during SETTLING, feedback with `swb_en_n` = `swc_en_n` = 0. Expect `dec_illegal` = 1 and `fault_code` = 2 at +20 cycles.
- Glitch immunity: in LOCKED, toggle `fb_swa` for 10 cycles, then restore. Expect `dec_valid` low for the glitch plus debounce, `locked` remaining 1, and no fault.
- Drift: in LOCKED with ant = 0, hold `fb_swa` = 1 permanently. Expect `dec_ant_sel` = 2 and `fault_code` = 3 at +20 cycles. `fault_clr` then returns to IDLE with `fault_code` = 0.
- Priority and reset: in FAULT, assert `cmd_valid` and `fault_clr` in the same cycle. Expect SETTLING (`busy` = 1) with `fault_code` = 0. Then `rst` mid-SETTLING: expect all outputs 0 next cycle and IDLE.
